// File: rtl/shiftrow_pkg.sv
// Shared definitions for the ShiftRows pipeline: buffer states, NB legality,
// row shift offsets and byte addressing of the column-major state.
package shiftrow_pkg;

    localparam int COUNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    function automatic bit nb_legal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    // Rijndael row offsets; only the 256-bit block uses the wider 3/4 shifts.
    function automatic int shift_of(input int r, input int nb);
        case (r)
            0:       return 0;
            1:       return 1;
            2:       return (nb == 8) ? 3 : 2;
            default: return (nb == 8) ? 4 : 3;
        endcase
    endfunction

    function automatic int byte_idx(input int r, input int c);
        return 4 * c + r;
    endfunction

    // Byte 0 sits in the most significant position of the state vector.
    function automatic int byte_msb(input int nb, input int k);
        return 32 * nb - 1 - 8 * k;
    endfunction

endpackage

// File: rtl/shiftrow_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation.
// Inverse direction is only built when SHIFTROW_INV_EN is defined.
module shiftrow_perm
    import shiftrow_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [32*NB-1:0] state,
    input  logic             inv,
    output logic [32*NB-1:0] result
);

    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int DST     = byte_msb(NB, byte_idx(r, c));
            localparam int FWD_SRC = byte_msb(NB, byte_idx(r, (c + shift_of(r, NB)) % NB));
`ifdef SHIFTROW_INV_EN
            localparam int INV_SRC = byte_msb(NB, byte_idx(r, (c + NB - shift_of(r, NB)) % NB));
            assign result[DST -: 8] = inv ? state[INV_SRC -: 8] : state[FWD_SRC -: 8];
`else
            assign result[DST -: 8] = state[FWD_SRC -: 8];
`endif
        end
    end

`ifndef SHIFTROW_INV_EN
    // Forward-only build: the direction input is kept on the port but unused.
    logic unused_inv;
    assign unused_inv = inv;
`endif

endmodule

// File: rtl/shiftrow_pipe.sv
// One-cycle ShiftRows stage with a 2-entry (main + skid) output buffer.
// Define SHIFTROW_INV_EN to also build InvShiftRows selected by in_inv.
module shiftrow_pipe
    import shiftrow_pkg::*;
#(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [32*NB-1:0]   in_state,
    input  logic               in_inv,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [32*NB-1:0]   out_state,
    output logic [TAG_W-1:0]   out_tag,
    output logic [COUNT_W-1:0] count
);

    localparam int SW = 32 * NB;

    if (!nb_legal(NB)) begin : g_bad_nb
        $error("shiftrow_pipe: NB must be 4, 6 or 8");
    end

    // Handshake: a transfer happens on any rising edge where valid and ready are
    // both 1. Producers hold valid/data until the transfer; in_ready is a flop
    // that is low only while both entries are occupied.
    logic [SW-1:0] perm_state;

    shiftrow_perm #(.NB(NB)) u_perm (
        .state  (in_state),
        .inv    (in_inv),
        .result (perm_state)
    );

    buf_state_e         state_q, state_d;
    logic [SW-1:0]      main_data_q, skid_data_q;
    logic [TAG_W-1:0]   main_tag_q, skid_tag_q;
    logic               in_ready_q;
    logic [COUNT_W-1:0] count_q;

    logic in_fire, out_fire;
    logic load_main_in, load_main_skid, load_skid;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_state = main_data_q;
    assign out_tag   = main_tag_q;
    assign count     = count_q;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d      = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain path can fire.
                if (out_fire) begin
                    state_d        = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            main_data_q <= '0;
            main_tag_q  <= '0;
            skid_data_q <= '0;
            skid_tag_q  <= '0;
            count_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
            if (load_main_in) begin
                main_data_q <= perm_state;
                main_tag_q  <= in_tag;
            end else if (load_main_skid) begin
                main_data_q <= skid_data_q;
                main_tag_q  <= skid_tag_q;
            end
            if (load_skid) begin
                skid_data_q <= perm_state;
                skid_tag_q  <= in_tag;
            end
            if (out_fire) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shiftrow_pipe.sv
// Self-checking bench for shiftrow_pipe: vector table plus handshake,
// backpressure, reset and counter-wrap sequences for NB = 4, 6 and 8.
module tb_shiftrow_pipe;

    localparam int TW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic           in_valid4 = 1'b0, in_ready4, in_inv4 = 1'b0;
    logic [127:0]   in_state4 = '0, out_state4;
    logic [TW-1:0]  in_tag4 = '0, out_tag4;
    logic           out_valid4, out_ready4 = 1'b1;
    logic [15:0]    count4;

    logic           in_valid6 = 1'b0, in_ready6, in_inv6 = 1'b0, out_valid6;
    logic           out_ready6 = 1'b1;
    logic [191:0]   in_state6 = '0, out_state6;
    logic [TW-1:0]  in_tag6 = '0, out_tag6;
    logic [15:0]    count6;

    logic           in_valid8 = 1'b0, in_ready8, in_inv8 = 1'b0, out_valid8;
    logic           out_ready8 = 1'b1;
    logic [255:0]   in_state8 = '0, out_state8;
    logic [TW-1:0]  in_tag8 = '0, out_tag8;
    logic [15:0]    count8;

    shiftrow_pipe #(.NB(4), .TAG_W(TW)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_state(in_state4), .in_inv(in_inv4), .in_tag(in_tag4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_state(out_state4),
        .out_tag(out_tag4), .count(count4)
    );

    shiftrow_pipe #(.NB(6), .TAG_W(TW)) dut6 (
        .clk(clk), .rst(rst), .in_valid(in_valid6), .in_ready(in_ready6),
        .in_state(in_state6), .in_inv(in_inv6), .in_tag(in_tag6),
        .out_valid(out_valid6), .out_ready(out_ready6), .out_state(out_state6),
        .out_tag(out_tag6), .count(count6)
    );

    shiftrow_pipe #(.NB(8), .TAG_W(TW)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_state(in_state8), .in_inv(in_inv8), .in_tag(in_tag8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_state(out_state8),
        .out_tag(out_tag8), .count(count8)
    );

    // Reference model: builds the permutation from the row-shift table directly.
    function automatic logic [255:0] model(input logic [255:0] s, input int nb, input logic inv);
        logic [255:0] o;
        int sh, src;
        o = '0;
        for (int c = 0; c < nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                sh = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? ((nb == 8) ? 3 : 2) : ((nb == 8) ? 4 : 3);
`ifdef SHIFTROW_INV_EN
                src = inv ? (c + nb - sh) % nb : (c + sh) % nb;
`else
                src = (c + sh) % nb;
`endif
                o[32*nb-1-8*(4*c+r) -: 8] = s[32*nb-1-8*(4*src+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] model4(input logic [127:0] s, input logic inv);
        logic [255:0] w;
        w = model({128'h0, s}, 4, inv);
        return w[127:0];
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid4 = 1'b0; in_valid6 = 1'b0; in_valid8 = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Scoreboard for the NB=4 instance: push on accept, pop on output transfer.
    logic [TW+127:0] exp_q[$];
    logic [TW+127:0] exp_item;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid4 && out_ready4) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected actual=%0h required=none", {out_tag4, out_state4});
                end else begin
                    exp_item = exp_q.pop_front();
                    check("sb_order", {124'h0, out_tag4, out_state4}, {124'h0, exp_item});
                end
            end
            if (in_valid4 && in_ready4) begin
                exp_q.push_back({in_tag4, model4(in_state4, in_inv4)});
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [127:0]  state;
        logic          inv;
        logic [TW-1:0] tag;
        logic [127:0]  exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [255:0] x, y, pat8;
        logic [191:0] x6, y6;

        vecs[0] = '{128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 4'h1,
                    128'hd4bf5d30e0b452aeb84111f11e2798e5};
`ifdef SHIFTROW_INV_EN
        vecs[1] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, 4'h2,
                    128'hd42711aee0bf98f1b8b45de51e415230};
`else
        vecs[1] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, 4'h2,
                    model4(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1)};
`endif
        vecs[2] = '{128'h0, 1'b0, 4'h3, 128'h0};
        vecs[3] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b0, 4'h4,
                    128'h00050a0f04090e03080d02070c01060b};
        for (int i = 4; i < 6; i++) begin
            vecs[i].state = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].inv   = 1'($urandom_range(0, 1));
            vecs[i].tag   = TW'(i + 1);
            vecs[i].exp   = model4(vecs[i].state, vecs[i].inv);
        end

        // Reset values
        step();
        step();
        check("rst_out_valid", out_valid4, 0);
        check("rst_in_ready", in_ready4, 1);
        check("rst_out_state", out_state4, 0);
        check("rst_out_tag", out_tag4, 0);
        check("rst_count", count4, 0);
        rst = 1'b0;

        // Vector table, one state per cycle with the consumer ready
        out_ready4 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_state4 = vecs[i].state;
            in_inv4   = vecs[i].inv;
            in_tag4   = vecs[i].tag;
            in_valid4 = 1'b1;
            step();
            in_valid4 = 1'b0;
            check($sformatf("vec%0d_valid", i), out_valid4, 1);
            check($sformatf("vec%0d_state", i), out_state4, vecs[i].exp);
            check($sformatf("vec%0d_tag", i), out_tag4, vecs[i].tag);
        end
        step();
        in_inv4 = 1'b0;

        // NB=8 byte-index pattern
        for (int k = 0; k < 32; k++) pat8[255-8*k -: 8] = 8'(k);
        in_state8 = pat8; in_inv8 = 1'b0; in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        check("nb8_byte1", out_state8[247 -: 8], 8'h05);
        check("nb8_byte2", out_state8[239 -: 8], 8'h0e);
        check("nb8_byte3", out_state8[231 -: 8], 8'h13);
        step();

        // NB=6 / NB=8 round trips of random states
        for (int i = 0; i < 3; i++) begin
            x6 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            x  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            in_state6 = x6; in_inv6 = 1'b0; in_valid6 = 1'b1;
            in_state8 = x;  in_inv8 = 1'b0; in_valid8 = 1'b1;
            step();
            y6 = out_state6;
            y  = out_state8;
            check("nb6_fwd", y6, model({64'h0, x6}, 6, 1'b0));
            check("nb8_fwd", y, model(x, 8, 1'b0));
            in_state6 = y6; in_inv6 = 1'b1;
            in_state8 = y;  in_inv8 = 1'b1;
            step();
            in_valid6 = 1'b0; in_valid8 = 1'b0;
`ifdef SHIFTROW_INV_EN
            check("nb6_round_trip", out_state6, x6);
            check("nb8_round_trip", out_state8, x);
`else
            check("nb6_inv_ignored", out_state6, model({64'h0, y6}, 6, 1'b0));
            check("nb8_inv_ignored", out_state8, model(y, 8, 1'b0));
`endif
            step();
        end

        // Stream 10 states back to back
        do_reset();
        check("stream_count0", count4, 0);
        out_ready4 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_state4 = {$urandom, $urandom, $urandom, $urandom};
            in_tag4   = TW'(i);
            in_valid4 = 1'b1;
            step();
            check($sformatf("stream%0d_valid", i), out_valid4, 1);
            check($sformatf("stream%0d_tag", i), out_tag4, i);
        end
        in_valid4 = 1'b0;
        step();
        check("stream_count", count4, 10);
        check("stream_drained", out_valid4, 0);

        // Backpressure: third offer must be refused
        out_ready4 = 1'b0;
        in_valid4  = 1'b1;
        in_tag4 = 4'ha; in_state4 = {$urandom, $urandom, $urandom, $urandom};
        step();
        check("bp_ready_after_one", in_ready4, 1);
        in_tag4 = 4'hb; in_state4 = {$urandom, $urandom, $urandom, $urandom};
        step();
        check("bp_ready_full", in_ready4, 0);
        in_tag4 = 4'hc; in_state4 = {$urandom, $urandom, $urandom, $urandom};
        step();
        check("bp_hold_tag", out_tag4, 4'ha);
        check("bp_hold_valid", out_valid4, 1);
        in_valid4  = 1'b0;
        out_ready4 = 1'b1;
        step();
        check("bp_second_tag", out_tag4, 4'hb);
        check("bp_ready_back", in_ready4, 1);
        step();
        check("bp_empty", out_valid4, 0);
        check("bp_count", count4, 12);

        // Reset while FULL discards both entries
        out_ready4 = 1'b0;
        in_valid4  = 1'b1;
        repeat (2) begin
            in_state4 = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        check("full_before_rst", in_ready4, 0);
        rst = 1'b1;
        in_valid4 = 1'b0;
        step();
        rst = 1'b0;
        check("full_rst_valid", out_valid4, 0);
        check("full_rst_ready", in_ready4, 1);
        check("full_rst_count", count4, 0);
        out_ready4 = 1'b1;
        repeat (3) begin
            step();
            check("full_rst_no_ghost", out_valid4, 0);
        end

        // Counter wrap after 65535 transfers
        in_valid4 = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            in_state4 = {$urandom, $urandom, $urandom, $urandom};
            in_tag4   = TW'(i);
            step();
        end
        in_valid4 = 1'b0;
        step();
        check("count_ffff", count4, 16'hffff);
        in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        step();
        check("count_wrap", count4, 0);
        check("sb_empty_at_end", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shiftrow_pipe.md
SHIFTROW_PIPE -- requirements
Module: shiftrow_pipe

Interface
REQ-001 The module SHALL have parameter NB, default 4, meaning state columns (Rijndael block of 32*NB bits); legal values are 4, 6 and 8.
REQ-002 The module SHALL have parameter TAG_W, default 4, meaning the width of a sideband tag carried alongside each state.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port in_valid, input, 1 bit: an input state is offered.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the block accepts the offered state this cycle.
REQ-007 The module SHALL have port in_state, input, 32*NB bits: the input state.
REQ-008 The module SHALL have port in_inv, input, 1 bit: 0 selects ShiftRows and 1 selects InvShiftRows.
REQ-009 The module SHALL have port in_tag, input, TAG_W bits: a sideband tag.
REQ-010 The module SHALL have port out_valid, output, 1 bit: an output state is presented.
REQ-011 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the presented state.
REQ-012 The module SHALL have port out_state, output, 32*NB bits: the permuted state.
REQ-013 The module SHALL have port out_tag, output, TAG_W bits: the tag of out_state.
REQ-014 The module SHALL have port count, output, 16 bits: the number of completed output transfers.

Function
REQ-015 The state layout SHALL be column-major: byte k = 4*c + r (row r, column c), and byte 0 SHALL occupy bits [32*NB-1 : 32*NB-8].
REQ-016 Row shift s(r) SHALL be 0,1,2,3 for NB = 4 or 6, and 0,1,3,4 for NB = 8.
REQ-017 Forward operation SHALL produce out[r][c] = in[r][(c + s(r)) mod NB].
REQ-018 Inverse operation SHALL produce out[r][(c + s(r)) mod NB] = in[r][c].
REQ-019 A transfer SHALL occur on a cycle where valid and ready are both 1; in_inv and in_tag SHALL be sampled with in_state.
REQ-020 Latency SHALL be 1 cycle: a state accepted at edge N SHALL be presented on out_* immediately after edge N.
REQ-021 The datapath SHALL be a 2-entry buffer (main register plus skid register), giving full throughput of one transfer per cycle under continuous out_ready = 1.
REQ-022 The buffer state machine SHALL have the states EMPTY, ONE and FULL.
- EMPTY -> ONE on an input transfer.
- ONE -> ONE on a simultaneous input and output transfer.
- ONE -> FULL on an input transfer with out_ready = 0.
- ONE -> EMPTY on an output transfer only.
- FULL -> ONE on an output transfer; the skid entry SHALL move to the main register.
REQ-023 in_ready SHALL be registered and SHALL equal 0 only in FULL, so it carries no combinational path from out_ready.
REQ-024 Outputs SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-025 Order SHALL be preserved: outputs SHALL leave in acceptance order, with tags matching.
REQ-026 count SHALL increment on each output transfer and SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-027 With rst = 1 at a rising edge, the state SHALL go to EMPTY and the outputs SHALL become out_valid = 0, in_ready = 1, out_state = 0, out_tag = 0 and count = 0.
REQ-028 A reset mid-operation SHALL discard all buffered states without presenting them.
REQ-029 No transfer SHALL be counted or accepted on a reset cycle.

Configuration
REQ-030 With macro SHIFTROW_INV_EN defined, both directions SHALL be implemented per in_inv.
REQ-031 Without SHIFTROW_INV_EN, in_inv SHALL be ignored, only forward ShiftRows SHALL be built, and the port SHALL remain present.

Structure
REQ-032 Package shiftrow_pkg SHALL hold the NB legality check, the shift-offset function s(r, NB), the byte-index helper, and the COUNT_W = 16 constant.
REQ-033 The combinational permutation SHALL live in sub-module shiftrow_perm, with parameter NB and inputs state and inv; it SHALL be instantiated once ahead of the buffer.

Verification
REQ-034 For NB = 4, forward, input d42711aee0bf98f1b8b45de51e415230 SHALL produce d4bf5d30e0b452aeb84111f11e2798e5 one cycle later.
REQ-035 For NB = 4, inverse, input d4bf5d30e0b452aeb84111f11e2798e5 SHALL produce d42711aee0bf98f1b8b45de51e415230, and the same check SHALL be repeated for NB = 6 and NB = 8 with a round-trip of random states.
REQ-036 For NB = 8, an input with byte k = k (00..1f) SHALL produce byte 1 = 05, byte 2 = 0e and byte 3 = 13 in column 0.
REQ-037 Streaming 10 states with out_ready = 1 SHALL produce 10 outputs on consecutive cycles, in order with matching tags, and count = 10.
REQ-038 With out_ready = 0 and 3 states offered, 2 SHALL be accepted, in_ready SHALL drop after the second, and releasing out_ready SHALL deliver both in order.
REQ-039 Asserting rst in FULL SHALL produce out_valid = 0 and in_ready = 1 the next cycle, and the old states SHALL never appear; with count preloaded to 0xFFFF by 65535 transfers, the next transfer SHALL give count = 0.
